traffic_light_controller: RTL and testbench



---
 rtl/traffic_light_controller.sv | 155 +++++++++++++++
 tb/tb_traffic_light_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - two-road traffic-light sequencer with congestion-stretched main green (optional ALL_RED_EN clearance phases)
module traffic_light_controller #(
  parameter int MAIN_GREEN_T      = 10,
  parameter int MAIN_GREEN_CONG_T = 20,
  parameter int SIDE_GREEN_T      = 5,
  parameter int YELLOW_T          = 3,
  parameter int ALL_RED_T         = 2,
  parameter int CNT_W             = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       congestion,
  output logic [1:0] main_road,
  output logic [1:0] side_road
);

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  // Last counter value of each phase; the phase ends on the edge where cnt reaches it.
  localparam logic [CNT_W-1:0] MG_LAST  = CNT_W'(MAIN_GREEN_T - 1);
  localparam logic [CNT_W-1:0] MGC_LAST = CNT_W'(MAIN_GREEN_CONG_T - 1);
  localparam logic [CNT_W-1:0] SG_LAST  = CNT_W'(SIDE_GREEN_T - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_T - 1);
`ifdef ALL_RED_EN
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_T - 1);
`endif

  // Every dwell must fit the counter: 1 <= T <= 2^CNT_W.
  if (MAIN_GREEN_T < 1 || MAIN_GREEN_T > 2**CNT_W ||
      MAIN_GREEN_CONG_T < 1 || MAIN_GREEN_CONG_T > 2**CNT_W ||
      SIDE_GREEN_T < 1 || SIDE_GREEN_T > 2**CNT_W ||
      YELLOW_T < 1 || YELLOW_T > 2**CNT_W ||
      ALL_RED_T < 1 || ALL_RED_T > 2**CNT_W) begin : g_bad_dwell
    $error("traffic_light_controller: dwell parameter out of range for CNT_W");
  end

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    SIDE_GREEN  = 3'd2,
`ifdef ALL_RED_EN
    SIDE_YELLOW = 3'd3,
    ALL_RED_1   = 3'd4,
    ALL_RED_2   = 3'd5
`else
    SIDE_YELLOW = 3'd3
`endif
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               cong_lat;

  // Phase sequencer: state, dwell counter, congestion latch and registered lamp outputs move together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= MAIN_GREEN;
      cnt       <= '0;
      cong_lat  <= congestion;
      main_road <= GREEN;
      side_road <= RED;
    end else begin
      case (state)
        MAIN_GREEN: begin
          if (cnt == (cong_lat ? MGC_LAST : MG_LAST)) begin
            state     <= MAIN_YELLOW;
            cnt       <= '0;
            main_road <= YELLOW;
            side_road <= RED;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MAIN_YELLOW: begin
          if (cnt == Y_LAST) begin
`ifdef ALL_RED_EN
            state     <= ALL_RED_1;
            main_road <= RED;
            side_road <= RED;
`else
            state     <= SIDE_GREEN;
            main_road <= RED;
            side_road <= GREEN;
`endif
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef ALL_RED_EN
        ALL_RED_1: begin
          if (cnt == AR_LAST) begin
            state     <= SIDE_GREEN;
            cnt       <= '0;
            main_road <= RED;
            side_road <= GREEN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        SIDE_GREEN: begin
          if (cnt == SG_LAST) begin
            state     <= SIDE_YELLOW;
            cnt       <= '0;
            main_road <= RED;
            side_road <= YELLOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SIDE_YELLOW: begin
          if (cnt == Y_LAST) begin
`ifdef ALL_RED_EN
            state     <= ALL_RED_2;
            main_road <= RED;
            side_road <= RED;
`else
            state     <= MAIN_GREEN;
            cong_lat  <= congestion;
            main_road <= GREEN;
            side_road <= RED;
`endif
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef ALL_RED_EN
        ALL_RED_2: begin
          if (cnt == AR_LAST) begin
            state     <= MAIN_GREEN;
            cnt       <= '0;
            cong_lat  <= congestion;
            main_road <= GREEN;
            side_road <= RED;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: begin
          state     <= MAIN_GREEN;
          cnt       <= '0;
          cong_lat  <= congestion;
          main_road <= GREEN;
          side_road <= RED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - directed scoreboard bench for traffic_light_controller
module tb_traffic_light_controller;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       congestion = 1'b0;
  logic [1:0] main_road;
  logic [1:0] side_road;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] sb[$];
  logic [1:0] prev_main, prev_side;
  logic       have_prev = 1'b0;

  traffic_light_controller dut (
    .clock      (clock),
    .reset      (reset),
    .congestion (congestion),
    .main_road  (main_road),
    .side_road  (side_road)
  );

  always #5 clock = ~clock;

  function automatic logic legal_step(logic [1:0] a, logic [1:0] b);
    return (a == b) || (a == G && b == Y) || (a == Y && b == R) || (a == R && b == G);
  endfunction

  task automatic push_phase(logic [1:0] m, logic [1:0] s, int n);
    for (int i = 0; i < n; i++) sb.push_back({m, s});
  endtask

  // One full period starting at MAIN_GREEN entry.
  task automatic push_period(bit cong);
    push_phase(G, R, cong ? 20 : 10);
    push_phase(Y, R, 3);
`ifdef ALL_RED_EN
    push_phase(R, R, 2);
`endif
    push_phase(R, G, 5);
    push_phase(R, Y, 3);
`ifdef ALL_RED_EN
    push_phase(R, R, 2);
`endif
  endtask

  task automatic check_invariants(string tag);
    n_assert++;
    assert (main_road == R || side_road == R) else begin
      n_fail++;
      $error("FAIL %s both_lit: observed main=%b side=%b, required one road RED", tag, main_road, side_road);
    end
    n_assert++;
    assert (main_road !== 2'b11 && side_road !== 2'b11) else begin
      n_fail++;
      $error("FAIL %s bad_code: observed main=%b side=%b, required no 11", tag, main_road, side_road);
    end
    if (have_prev) begin
      n_assert++;
      assert (legal_step(prev_main, main_road) && legal_step(prev_side, side_road)) else begin
        n_fail++;
        $error("FAIL %s order: observed main %b->%b side %b->%b, required G->Y->R->G", tag,
               prev_main, main_road, prev_side, side_road);
      end
    end
    prev_main = main_road;
    prev_side = side_road;
    have_prev = 1'b1;
  endtask

  // Called #1 after an active edge: compare the current lamps against the scoreboard head.
  task automatic check_next(string tag);
    logic [3:0] exp;
    exp = sb.pop_front();
    n_assert++;
    assert ({main_road, side_road} === exp) else begin
      n_fail++;
      $error("FAIL %s lamps: observed main=%b side=%b, required main=%b side=%b", tag,
             main_road, side_road, exp[3:2], exp[1:0]);
    end
    check_invariants(tag);
  endtask

  task automatic run(int n, string tag);
    for (int i = 0; i < n; i++) begin
      check_next(tag);
      @(posedge clock); #1;
    end
  endtask

  task automatic drain(string tag);
    run(sb.size(), tag);
  endtask

  task automatic apply_reset(bit c);
    reset = 1'b1;
    congestion = c;
    @(posedge clock); #1;
    reset = 1'b0;
    have_prev = 1'b0;
  endtask

  initial begin
    // Uncongested period, then return to main green.
    push_period(1'b0);
    push_phase(G, R, 10);
    apply_reset(1'b0);
    drain("uncong");

    // Congestion held high: 20-cycle main green, period 31 (35 with all-red).
    push_period(1'b1);
    push_phase(G, R, 20);
    apply_reset(1'b1);
    drain("cong");

    // Congestion rises at cycle 4 of an uncongested green: takes effect next period.
    push_period(1'b0);
    push_phase(G, R, 20);
    push_phase(Y, R, 3);
    apply_reset(1'b0);
    run(3, "late_cong");
    congestion = 1'b1;
    drain("late_cong");

    // Reset pulse in the third cycle of side green.
    congestion = 1'b0;
    apply_reset(1'b0);
    push_phase(G, R, 10);
    push_phase(Y, R, 3);
`ifdef ALL_RED_EN
    push_phase(R, R, 2);
`endif
    push_phase(R, G, 2);
    drain("pre_pulse");
    apply_reset(1'b0);
    push_phase(G, R, 10);
    push_phase(Y, R, 1);
    drain("post_pulse");

    // Random congestion changes every 20 cycles: safety invariants only.
    for (int i = 0; i < 1000; i++) begin
      if (i % 20 == 0) congestion = 1'($urandom_range(0, 1));
      check_invariants("random");
      @(posedge clock); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
